// File: rtl/fetch_queue_unit_pkg.sv
// ============================================================================
// Module : fetch_queue_unit_pkg
// Brief  : Opcode constants, immediate helpers and FSM encodings for fetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_queue_unit_pkg;

  localparam int OPTYPE_MSB = 6;
  localparam int OPTYPE_LSB = 0;
  localparam int OPTYPE_W   = OPTYPE_MSB - OPTYPE_LSB + 1;

  localparam logic [OPTYPE_W-1:0] OP_JAL  = 7'b1101111;
  localparam logic [OPTYPE_W-1:0] OP_JALR = 7'b1100111;
  localparam logic [OPTYPE_W-1:0] OP_BR   = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_DISCARD  = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] j_imm(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] b_imm(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue_unit_inst_queue.sv
// ============================================================================
// Module : inst_queue
// Brief  : Power-of-two ring FIFO with flush, full flag and occupancy count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  // A pop never frees space for a push in the same cycle.
  assign w_do_push = i_en && !i_flush && i_push && !o_full;
  assign w_do_pop  = i_en && !i_flush && i_pop && (r_count != '0);
  assign o_head    = (r_count != '0) ? r_mem[r_head] : '0;

  always_ff @(posedge clk_in) begin
    if (w_do_push) r_mem[r_tail] <= i_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_en) begin
      if (i_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_do_push) r_tail <= r_tail + PTR_W'(1);
        if (w_do_pop)  r_head <= r_head + PTR_W'(1);
        if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
        else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_queue_unit.sv
// ============================================================================
// Module : fetch_queue_unit
// Brief  : Queued instruction fetch (I-cache hit / memory miss, JAL/BR predict).
//          Optional FETCH_STATS_EN adds stat_hits/stat_misses/stat_flushes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                IQ_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clr_in,
  input  logic [ADDR_W-1:0] rob_to_if_alter_pc,
  output logic              if_to_mc_ready,
  output logic [ADDR_W-1:0] if_to_mc_PC,
  input  logic              mc_to_if_ready,
  input  logic [INST_W-1:0] mc_to_if_inst,
  output logic [ADDR_W-1:0] if_to_ic_inst_addr,
  input  logic              ic_to_if_hit,
  input  logic [INST_W-1:0] ic_to_if_hit_inst,
  output logic              if_to_ic_inst_valid,
  output logic [ADDR_W-1:0] if_to_ic_fill_addr,
  output logic [INST_W-1:0] if_to_ic_inst,
  output logic [ADDR_W-1:0] if_to_pr_PC,
  input  logic              pr_to_if_prediction,
`ifdef FETCH_STATS_EN
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_flushes,
`endif
  output logic              if_to_dc_ready,
  input  logic              dc_to_if_accept,
  output logic [INST_W-1:0] if_to_dc_inst,
  output logic [ADDR_W-1:0] if_to_dc_PC,
  output logic              if_to_dc_pred_br
);

  localparam int ENT_W = INST_W + ADDR_W + 1;
  localparam int CNT_W = $clog2(IQ_DEPTH + 1);

  fetch_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic              r_req, w_req_nxt;
  logic [ADDR_W-1:0] r_req_pc, w_req_pc_nxt;
  logic              w_push, w_fill, w_hit_push, w_miss;
  logic [INST_W-1:0] w_inst;
  logic [31:0]       w_imm;
  logic              w_taken;
  logic [ADDR_W-1:0] w_npc;
  logic              w_full;
  logic [CNT_W-1:0]  w_count;
  logic [ENT_W-1:0]  w_head;

  // Only the memory response is consumed in WAIT_MEM; otherwise the hit path.
  assign w_inst = (r_state == ST_WAIT_MEM) ? mc_to_if_inst : ic_to_if_hit_inst;

  always_comb begin
    w_imm   = '0;
    w_taken = 1'b0;
    case (w_inst[OPTYPE_MSB:OPTYPE_LSB])
      OP_JAL:  begin w_imm = j_imm(w_inst[31:0]); w_taken = 1'b1; end
      OP_BR:   begin w_imm = b_imm(w_inst[31:0]); w_taken = pr_to_if_prediction; end
      OP_JALR: w_taken = 1'b0;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_npc = w_taken ? r_pc + ADDR_W'($signed(w_imm)) : r_pc + ADDR_W'(4);

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_req_nxt    = r_req;
    w_req_pc_nxt = r_req_pc;
    w_push       = 1'b0;
    w_fill       = 1'b0;
    w_hit_push   = 1'b0;
    w_miss       = 1'b0;
    if (clr_in) begin
      w_pc_nxt = rob_to_if_alter_pc;
      if (r_state != ST_IDLE) begin
        if (mc_to_if_ready) begin
          w_state_nxt = ST_IDLE;
          w_req_nxt   = 1'b0;
        end else begin
          w_state_nxt = ST_DISCARD;
        end
      end
    end else begin
      case (r_state)
        ST_IDLE: if (!w_full) begin
          if (ic_to_if_hit) begin
            w_push     = 1'b1;
            w_hit_push = 1'b1;
            w_pc_nxt   = w_npc;
          end else begin
            w_req_nxt    = 1'b1;
            w_req_pc_nxt = r_pc;
            w_miss       = 1'b1;
            w_state_nxt  = ST_WAIT_MEM;
          end
        end
        ST_WAIT_MEM: if (mc_to_if_ready) begin
          w_push      = 1'b1;
          w_fill      = 1'b1;
          w_pc_nxt    = w_npc;
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end
        ST_DISCARD: if (mc_to_if_ready) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_req    <= 1'b0;
      r_req_pc <= RESET_PC;
    end else if (rdy_in) begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_req    <= w_req_nxt;
      r_req_pc <= w_req_pc_nxt;
    end
  end

  inst_queue #(
    .DEPTH (IQ_DEPTH),
    .WIDTH (ENT_W),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_en    (rdy_in),
    .i_flush (clr_in),
    .i_push  (w_push),
    .i_data  ({w_inst, r_pc, w_taken}),
    .i_pop   (if_to_dc_ready && dc_to_if_accept),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_count (w_count)
  );

  assign if_to_mc_ready      = r_req;
  assign if_to_mc_PC         = r_req_pc;
  assign if_to_ic_inst_addr  = r_pc;
  assign if_to_pr_PC         = r_pc;
  assign if_to_ic_inst_valid = w_fill && rdy_in;
  assign if_to_ic_fill_addr  = r_pc;
  assign if_to_ic_inst       = if_to_ic_inst_valid ? mc_to_if_inst : '0;
  assign if_to_dc_ready      = (w_count != '0);
  assign {if_to_dc_inst, if_to_dc_PC, if_to_dc_pred_br} = w_head;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stat_hits    <= '0;
      stat_misses  <= '0;
      stat_flushes <= '0;
    end else if (rdy_in) begin
      if (w_hit_push) stat_hits    <= stat_hits + 32'd1;
      if (w_miss)     stat_misses  <= stat_misses + 32'd1;
      if (clr_in)     stat_flushes <= stat_flushes + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
// ============================================================================
// Module : tb_fetch_queue_unit
// Brief  : Directed scoreboard bench for fetch_queue_unit (default build).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue_unit;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in;
  logic [31:0] rob_to_if_alter_pc;
  logic        if_to_mc_ready;
  logic [31:0] if_to_mc_PC;
  logic        mc_to_if_ready;
  logic [31:0] mc_to_if_inst;
  logic [31:0] if_to_ic_inst_addr;
  logic        ic_to_if_hit;
  logic [31:0] ic_to_if_hit_inst;
  logic        if_to_ic_inst_valid;
  logic [31:0] if_to_ic_fill_addr;
  logic [31:0] if_to_ic_inst;
  logic [31:0] if_to_pr_PC;
  logic        pr_to_if_prediction;
  logic        if_to_dc_ready;
  logic        dc_to_if_accept;
  logic [31:0] if_to_dc_inst;
  logic [31:0] if_to_dc_PC;
  logic        if_to_dc_pred_br;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  ent_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_in = ~clk_in;

  fetch_queue_unit #(
    .ADDR_W   (32),
    .INST_W   (32),
    .IQ_DEPTH (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .rdy_in              (rdy_in),
    .clr_in              (clr_in),
    .rob_to_if_alter_pc  (rob_to_if_alter_pc),
    .if_to_mc_ready      (if_to_mc_ready),
    .if_to_mc_PC         (if_to_mc_PC),
    .mc_to_if_ready      (mc_to_if_ready),
    .mc_to_if_inst       (mc_to_if_inst),
    .if_to_ic_inst_addr  (if_to_ic_inst_addr),
    .ic_to_if_hit        (ic_to_if_hit),
    .ic_to_if_hit_inst   (ic_to_if_hit_inst),
    .if_to_ic_inst_valid (if_to_ic_inst_valid),
    .if_to_ic_fill_addr  (if_to_ic_fill_addr),
    .if_to_ic_inst       (if_to_ic_inst),
    .if_to_pr_PC         (if_to_pr_PC),
    .pr_to_if_prediction (pr_to_if_prediction),
    .if_to_dc_ready      (if_to_dc_ready),
    .dc_to_if_accept     (dc_to_if_accept),
    .if_to_dc_inst       (if_to_dc_inst),
    .if_to_dc_PC         (if_to_dc_PC),
    .if_to_dc_pred_br    (if_to_dc_pred_br)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] inst, input logic [31:0] pc, input logic pred);
    ent_t e;
    e.inst = inst;
    e.pc   = pc;
    e.pred = pred;
    sb.push_back(e);
  endtask

  task automatic check_head(input string tag);
    ent_t e;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL %s: observed=scoreboard-empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb[0];
      chk({tag, ".ready"}, 64'(if_to_dc_ready), 64'd1);
      chk({tag, ".inst"},  64'(if_to_dc_inst),  64'(e.inst));
      chk({tag, ".pc"},    64'(if_to_dc_PC),    64'(e.pc));
      chk({tag, ".pred"},  64'(if_to_dc_pred_br), 64'(e.pred));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0; rob_to_if_alter_pc = '0;
    mc_to_if_ready = 1'b0; mc_to_if_inst = '0; ic_to_if_hit = 1'b0;
    ic_to_if_hit_inst = '0; pr_to_if_prediction = 1'b0; dc_to_if_accept = 1'b0;
    repeat (2) tick();
    settle();
    chk("rst_mc_ready", 64'(if_to_mc_ready), 64'd0);
    chk("rst_mc_pc",    64'(if_to_mc_PC),    64'd0);
    chk("rst_ic_addr",  64'(if_to_ic_inst_addr), 64'd0);
    chk("rst_dc_ready", 64'(if_to_dc_ready), 64'd0);
    chk("rst_fill",     64'(if_to_ic_inst_valid), 64'd0);
    chk("rst_dc_inst",  64'(if_to_dc_inst),  64'd0);

    // Miss at reset PC, memory response fills cache and queue
    rst_in = 1'b1;
    tick();
    chk("miss0_req", 64'(if_to_mc_ready), 64'd1);
    chk("miss0_pc",  64'(if_to_mc_PC),    64'd0);
    mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h0000_0013;
    settle();
    chk("fill0_valid", 64'(if_to_ic_inst_valid), 64'd1);
    chk("fill0_addr",  64'(if_to_ic_fill_addr),  64'd0);
    chk("fill0_inst",  64'(if_to_ic_inst),       64'h13);
    exp_push(32'h13, 32'h0, 1'b0);
    tick();
    mc_to_if_ready = 1'b0;
    settle();
    check_head("head0");
    chk("pc_after0", 64'(if_to_ic_inst_addr), 64'd4);
    chk("req_drop0", 64'(if_to_mc_ready), 64'd0);
    tick();
    chk("miss4_req", 64'(if_to_mc_ready), 64'd1);
    chk("miss4_pc",  64'(if_to_mc_PC),    64'd4);
    mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h0010_0093;
    settle();
    exp_push(32'h0010_0093, 32'h4, 1'b0);
    tick();
    mc_to_if_ready = 1'b0;
    dc_to_if_accept = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      check_head("drain_a");
      tick();
      void'(sb.pop_front());
    end
    dc_to_if_accept = 1'b0;
    settle();
    chk("drain_a_empty", 64'(if_to_dc_ready), 64'd0);
    chk("miss8_req", 64'(if_to_mc_ready), 64'd1);
    chk("miss8_pc",  64'(if_to_mc_PC),    64'd8);

    // Flush during WAIT_MEM, response arrives later and is discarded
    clr_in = 1'b1; rob_to_if_alter_pc = 32'h400;
    settle();
    tick();
    clr_in = 1'b0;
    settle();
    chk("flush_dc_ready", 64'(if_to_dc_ready), 64'd0);
    chk("flush_pc",       64'(if_to_ic_inst_addr), 64'h400);
    chk("discard_req_held", 64'(if_to_mc_PC), 64'd8);
    tick();
    mc_to_if_ready = 1'b1; mc_to_if_inst = 32'hDEAD_BEEF;
    settle();
    chk("discard_no_fill", 64'(if_to_ic_inst_valid), 64'd0);
    tick();
    mc_to_if_ready = 1'b0;
    settle();
    chk("discard_req_drop", 64'(if_to_mc_ready), 64'd0);
    chk("discard_no_push",  64'(if_to_dc_ready), 64'd0);
    tick();
    chk("miss400_req", 64'(if_to_mc_ready), 64'd1);
    chk("miss400_pc",  64'(if_to_mc_PC),    64'h400);
    mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h13;
    settle();
    exp_push(32'h13, 32'h400, 1'b0);
    tick();
    mc_to_if_ready = 1'b0;
    settle();
    check_head("head400");

    // Flush from IDLE back to PC 0, then fill the queue with hits
    clr_in = 1'b1; rob_to_if_alter_pc = 32'h0;
    settle();
    tick();
    sb.delete();
    clr_in = 1'b0;
    settle();
    chk("flush2_dc_ready", 64'(if_to_dc_ready), 64'd0);
    chk("flush2_pc",       64'(if_to_ic_inst_addr), 64'd0);
    for (int k = 0; k < 5; k++) begin
      ic_to_if_hit = 1'b1;
      ic_to_if_hit_inst = 32'h13 | (32'(k) << 7);
      settle();
      chk("hit_pc", 64'(if_to_ic_inst_addr), 64'(4 * ((k < 4) ? k : 4)));
      if (k < 4) exp_push(32'h13 | (32'(k) << 7), 32'(4 * k), 1'b0);
      tick();
    end
    settle();
    chk("full_pc_stall", 64'(if_to_ic_inst_addr), 64'd16);
    chk("full_no_req",   64'(if_to_mc_ready), 64'd0);

    // Pop while full: the hit offered the same cycle must not be pushed
    dc_to_if_accept = 1'b1;
    ic_to_if_hit_inst = 32'h13 | (32'd4 << 7);
    settle();
    check_head("full_pop");
    tick();
    void'(sb.pop_front());
    ic_to_if_hit = 1'b0;
    settle();
    chk("full_pop_pc", 64'(if_to_ic_inst_addr), 64'd16);
    check_head("pop3");
    tick();
    void'(sb.pop_front());
    chk("miss16_req", 64'(if_to_mc_ready), 64'd1);
    chk("miss16_pc",  64'(if_to_mc_PC),    64'd16);
    // Push and pop together at count=2 across the pointer wrap
    mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h13 | (32'd4 << 7);
    settle();
    check_head("pp_mem");
    chk("fill16_valid", 64'(if_to_ic_inst_valid), 64'd1);
    exp_push(32'h13 | (32'd4 << 7), 32'd16, 1'b0);
    tick();
    void'(sb.pop_front());
    mc_to_if_ready = 1'b0;
    ic_to_if_hit = 1'b1; ic_to_if_hit_inst = 32'h13 | (32'd5 << 7);
    settle();
    chk("pp_hit_pc", 64'(if_to_ic_inst_addr), 64'd20);
    check_head("pp_hit");
    exp_push(32'h13 | (32'd5 << 7), 32'd20, 1'b0);
    tick();
    void'(sb.pop_front());
    ic_to_if_hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check_head("wrap_drain");
      tick();
      void'(sb.pop_front());
    end
    dc_to_if_accept = 1'b0;
    settle();
    chk("wrap_empty", 64'(if_to_dc_ready), 64'd0);
    chk("miss24_pc",  64'(if_to_mc_PC),    64'd24);

    // Flush with the response in the same cycle
    clr_in = 1'b1; rob_to_if_alter_pc = 32'h100;
    mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h13;
    settle();
    chk("flush_resp_no_fill", 64'(if_to_ic_inst_valid), 64'd0);
    tick();
    clr_in = 1'b0; mc_to_if_ready = 1'b0;
    settle();
    chk("flush_resp_req", 64'(if_to_mc_ready), 64'd0);
    chk("flush_resp_dc",  64'(if_to_dc_ready), 64'd0);
    chk("flush_resp_pc",  64'(if_to_ic_inst_addr), 64'h100);

    // JAL hit: +8
    ic_to_if_hit = 1'b1; ic_to_if_hit_inst = 32'h0080_006F;
    settle();
    exp_push(32'h0080_006F, 32'h100, 1'b1);
    tick();
    ic_to_if_hit_inst = 32'h13;
    settle();
    chk("jal_target", 64'(if_to_ic_inst_addr), 64'h108);
    check_head("jal_head");
    tick();
    ic_to_if_hit = 1'b0;
    clr_in = 1'b1; rob_to_if_alter_pc = 32'h200;
    settle();
    tick();
    sb.delete();
    clr_in = 1'b0;

    // BR -8 taken, BR not taken, JALR (prediction ignored)
    ic_to_if_hit = 1'b1; ic_to_if_hit_inst = 32'hFE00_0CE3; pr_to_if_prediction = 1'b1;
    settle();
    chk("br_pr_pc", 64'(if_to_pr_PC), 64'h200);
    exp_push(32'hFE00_0CE3, 32'h200, 1'b1);
    tick();
    pr_to_if_prediction = 1'b0;
    settle();
    chk("br_taken_target", 64'(if_to_ic_inst_addr), 64'h1F8);
    exp_push(32'hFE00_0CE3, 32'h1F8, 1'b0);
    tick();
    ic_to_if_hit_inst = 32'h0000_80E7; pr_to_if_prediction = 1'b1;
    settle();
    chk("br_nt_target", 64'(if_to_ic_inst_addr), 64'h1FC);
    exp_push(32'h0000_80E7, 32'h1FC, 1'b0);
    tick();
    ic_to_if_hit = 1'b0; pr_to_if_prediction = 1'b0;
    settle();
    chk("jalr_target", 64'(if_to_ic_inst_addr), 64'h200);
    dc_to_if_accept = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_head("pred_drain");
      tick();
      void'(sb.pop_front());
    end
    dc_to_if_accept = 1'b0;
    settle();
    chk("pred_empty", 64'(if_to_dc_ready), 64'd0);
    chk("miss200_pc", 64'(if_to_mc_PC),    64'h200);

    // rdy_in low freezes state and masks the fill strobe
    rdy_in = 1'b0; mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h13;
    settle();
    chk("rdy_no_fill", 64'(if_to_ic_inst_valid), 64'd0);
    tick();
    rdy_in = 1'b1; mc_to_if_ready = 1'b0;
    settle();
    chk("rdy_req_held", 64'(if_to_mc_ready), 64'd1);
    chk("rdy_no_push",  64'(if_to_dc_ready), 64'd0);
    mc_to_if_ready = 1'b1;
    settle();
    chk("fill200_valid", 64'(if_to_ic_inst_valid), 64'd1);
    chk("fill200_addr",  64'(if_to_ic_fill_addr),  64'h200);
    exp_push(32'h13, 32'h200, 1'b0);
    tick();
    mc_to_if_ready = 1'b0;
    settle();
    check_head("head200");
    tick();
    chk("miss204_req", 64'(if_to_mc_ready), 64'd1);

    // Asynchronous reset mid-miss
    rst_in = 1'b0;
    #1;
    chk("arst_req",      64'(if_to_mc_ready), 64'd0);
    chk("arst_dc_ready", 64'(if_to_dc_ready), 64'd0);
    chk("arst_pc",       64'(if_to_ic_inst_addr), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
